// File: rtl/spi_pkg.sv
// Shared FSM state, latched transfer mode and default sizing for the gen2 SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_N_SLAVES = 3;
  localparam int DEF_DIV_W    = 8;

  // cpha=0 samples MISO on leading SCLK edges, cpha=1 on trailing ones.
  function automatic logic is_sample_edge(input mode_t m, input logic lead, input logic trail);
    return m.cpha ? trail : lead;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and SCLK toggle; lead/trail strobes fire in the cycle whose edge moves SCLK.
// tick marks the last cycle of each H-cycle period; SCLK tracks idle_lvl while not running.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             edge_ok,
  input  logic             idle_lvl,
  input  logic             cpol,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             toggle;

  assign tick       = run && (cnt_q == div);
  assign toggle     = tick && edge_ok;
  // A toggle away from the idle level is a leading edge.
  assign lead_edge  = toggle && (sclk_q == cpol);
  assign trail_edge = toggle && (sclk_q != cpol);
  assign sclk       = sclk_q;

  always_comb begin
    cnt_d  = (!run || tick) ? '0 : cnt_q + DIV_W'(1);
    sclk_d = sclk_q;
    if (!run) begin
      sclk_d = idle_lvl;
    end else if (toggle) begin
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_gen2.sv
// SPI master: one DATA_W word per transfer, any CPOL/CPHA, MSB/LSB first, programmable SCLK divider.
// done pulses 1+H*(2*DATA_W+2) edges after start; start is ignored while busy (no queueing).
module spi_master_gen2
  import spi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_SLAVES = DEF_N_SLAVES,
  parameter int SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SEL_W-1:0]    slaveSelect,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsbFirst,
  input  logic [DIV_W-1:0]    clkDiv,
  input  logic [DATA_W-1:0]   masterDataToSend,
  output logic [DATA_W-1:0]   masterDataReceived,
  output logic                busy,
  output logic                done,
  output logic                SCLK,
  output logic [N_SLAVES-1:0] CS,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int CNT_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);
  localparam logic [CNT_W-1:0] PEN_EDGE  = CNT_W'(2 * DATA_W - 1);

  state_e              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic [N_SLAVES-1:0] cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;

  logic run, edge_ok, tick, lead_edge, trail_edge, sample, shift_out;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // MISO enters opposite the shift direction so RX bit order matches TX.
  function automatic logic [DATA_W-1:0] rx_push(input logic [DATA_W-1:0] w, input logic b,
                                                input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign run     = (state_q != IDLE);
  assign edge_ok = (state_q == SETUP) || ((state_q == XFER) && (edge_q != LAST_EDGE));

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (reset),
    .run       (run),
    .edge_ok   (edge_ok),
    .idle_lvl  (cpol),
    .cpol      (mode_q.cpol),
    .div       (div_q),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sclk      (SCLK)
  );

  assign sample    = is_sample_edge(mode_q, lead_edge, trail_edge);
  // cpha=0 presents bit 0 during SETUP, so the final trailing edge has nothing left to shift.
  assign shift_out = mode_q.cpha ? lead_edge : (trail_edge && (edge_q != PEN_EDGE));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    edge_d  = edge_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && (int'(slaveSelect) < N_SLAVES)) begin
          state_d = SETUP;
          mode_d  = '{cpol: cpol, cpha: cpha, lsb_first: lsbFirst};
          div_d   = clkDiv;
          edge_d  = '0;
          rx_d    = '0;
          for (int i = 0; i < N_SLAVES; i++) begin
            cs_d[i] = (slaveSelect != SEL_W'(i));
          end
          if (cpha) begin
            tx_d   = masterDataToSend;
            mosi_d = 1'b0;
          end else begin
            tx_d   = shift_word(masterDataToSend, lsbFirst);
            mosi_d = first_bit(masterDataToSend, lsbFirst);
          end
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick && (edge_q == LAST_EDGE)) state_d = HOLD;
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_d    = '1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lead_edge || trail_edge) edge_d = edge_q + CNT_W'(1);
    if (sample) rx_d = rx_push(rx_q, MISO, mode_q.lsb_first);
    if (shift_out) begin
      mosi_d = first_bit(tx_q, mode_q.lsb_first);
      tx_d   = shift_word(tx_q, mode_q.lsb_first);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      div_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      edge_q  <= '0;
      cs_q    <= '1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      edge_q  <= edge_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign busy               = run;
  assign done               = done_q;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;
  assign masterDataReceived = rdata_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// Bench for spi_master_gen2: 8-bit/3-slave and 16-bit/4-slave instances, behavioural SPI slave,
// scoreboard of expected receive word, MOSI bit sequence and done cycle per transfer.
module tb_spi_master_gen2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, start16 = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic        loop = 1'b0, sel16 = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic [1:0]  sel8 = 2'd0, sel_16 = 2'd0;
  logic [7:0]  tx8 = 8'd0;
  logic [15:0] tx16 = 16'd0;

  logic [7:0]  rx8;
  logic [15:0] rx16;
  logic        busy8, done8, sclk8, mosi8, miso8;
  logic        busy16, done16, sclk16, mosi16, miso16;
  logic [2:0]  cs8;
  logic [3:0]  cs16;

  spi_master_gen2 dut8 (
    .clk(clk), .reset(reset), .start(start8), .slaveSelect(sel8),
    .cpol(cpol), .cpha(cpha), .lsbFirst(lsb_first), .clkDiv(clk_div),
    .masterDataToSend(tx8), .masterDataReceived(rx8), .busy(busy8), .done(done8),
    .SCLK(sclk8), .CS(cs8), .MOSI(mosi8), .MISO(miso8)
  );

  spi_master_gen2 #(.DATA_W(16), .N_SLAVES(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .slaveSelect(sel_16),
    .cpol(cpol), .cpha(cpha), .lsbFirst(lsb_first), .clkDiv(clk_div),
    .masterDataToSend(tx16), .masterDataReceived(rx16), .busy(busy16), .done(done16),
    .SCLK(sclk16), .CS(cs16), .MOSI(mosi16), .MISO(miso16)
  );

  // Observation mux: the slave model and monitor follow whichever DUT is under test.
  wire        sclk_m   = sel16 ? sclk16 : sclk8;
  wire        mosi_m   = sel16 ? mosi16 : mosi8;
  wire        cs_all_m = sel16 ? (&cs16) : (&cs8);
  wire        done_m   = sel16 ? done16 : done8;
  wire        busy_m   = sel16 ? busy16 : busy8;
  wire [15:0] rx_m     = sel16 ? rx16 : {8'h00, rx8};

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural slave: returns s_word in the configured mode, records MOSI in bit order.
  logic [15:0] s_word = 16'd0;
  logic [15:0] s_seq  = 16'd0;
  logic        s_bit  = 1'b0;
  int          s_sidx = 0, s_oidx = 0;

  function automatic logic bit_at(input logic [15:0] w, input int i);
    int d;
    d = sel16 ? 16 : 8;
    if (i >= d) return 1'b0;
    return lsb_first ? w[i] : w[d-1-i];
  endfunction

  assign miso8  = loop ? mosi8 : s_bit;
  assign miso16 = s_bit;

  always @(negedge cs_all_m) begin
    s_sidx = 0;
    s_seq  = 16'd0;
    if (cpha) begin
      s_bit  = 1'b0;
      s_oidx = 0;
    end else begin
      s_bit  = bit_at(s_word, 0);
      s_oidx = 1;
    end
  end

  always @(sclk_m) begin
    if (!cs_all_m) begin
      if ((sclk_m != cpol) != cpha) begin
        s_seq[s_sidx] = mosi_m;
        s_sidx++;
      end else begin
        s_bit = bit_at(s_word, s_oidx);
        s_oidx++;
      end
    end
  end

  typedef struct {
    logic [15:0] rx;
    int          cyc;
    logic [15:0] seq;
  } exp_t;
  exp_t sb[$];

  int   done_cnt = 0, cs_low_cnt = 0, toggles = 0, gap_bad = 0, last_t = -1, cur_h = 1;
  logic prev_sclk = 1'b0;

  // Done is registered off edge H*(2D+2) after the start edge, so it is seen here in that
  // cycle and is high at edge 1+H*(2D+2).
  always @(negedge clk) begin
    exp_t e;
    if (!cs_all_m) cs_low_cnt++;
    if (!cs_all_m && (sclk_m != prev_sclk)) begin
      if (last_t >= 0 && (cyc - last_t) != cur_h) gap_bad++;
      last_t = cyc;
      toggles++;
    end
    prev_sclk = sclk_m;
    if (done_m) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done_m), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("rx_word", 32'(rx_m), 32'(e.rx));
        chk("mosi_seq", 32'(s_seq), 32'(e.seq));
        chk("busy_at_done", 32'(busy_m), 32'(0));
      end
    end
  end

  task automatic wait_sb(input int budget, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  typedef struct {
    logic       cpol, cpha, lsb;
    logic [7:0] div;
    logic [1:0] sel;
    logic [7:0] tx, slv, exp_rx, exp_seq;
    logic       loop;
  } vec_t;
  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    logic [2:0] ecs;
    @(negedge clk);
    sel16 = 1'b0; cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
    clk_div = v.div; sel8 = v.sel; tx8 = v.tx; s_word = {8'h00, v.slv}; loop = v.loop;
    repeat (2) @(negedge clk);
    chk("idle_sclk", 32'(sclk8), 32'(v.cpol));
    cur_h = int'(v.div) + 1;
    toggles = 0; gap_bad = 0; cs_low_cnt = 0; last_t = -1;
    sb.push_back('{{8'h00, v.exp_rx}, cyc + 1 + cur_h * 18, {8'h00, v.exp_seq}});
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ecs = 3'b111;
    ecs[v.sel] = 1'b0;
    chk("cs_select", 32'(cs8), 32'(ecs));
    chk("busy_rise", 32'(busy8), 32'(1));
    wait_sb(200, "vec_timeout");
    chk("sclk_toggles", 32'(toggles), 32'(16));
    chk("half_period_gaps", 32'(gap_bad), 32'(0));
    chk("cs_low_cycles", 32'(cs_low_cnt), 32'(cur_h * 18));
    chk("cs_release", 32'(cs8), 32'(3'b111));
  endtask

  initial begin
    int base, hi, d, n, dc0;
    logic seen, drop;

    //          cpol cpha lsb div   sel   tx     slv    exp_rx exp_seq loop
    vt[0] = '{1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b1};
    vt[1] = '{1'b0, 1'b0, 1'b0, 8'd2, 2'd0, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'd2, 2'd1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'd2, 2'd2, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 8'h12, 8'h5A, 8'h5A, 8'h48, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_cs8", 32'(cs8), 32'(3'b111));
    chk("rst_cs16", 32'(cs16), 32'(4'b1111));
    chk("rst_sclk", 32'(sclk8), 32'(0));
    chk("rst_mosi", 32'(mosi8), 32'(0));
    chk("rst_rx", 32'(rx8), 32'(0));
    reset = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Out-of-range slave index: start must be ignored entirely.
    dc0 = done_cnt;
    sel8 = 2'd3; start8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bad_sel_cs", 32'(cs8), 32'(3'b111));
      chk("bad_sel_busy", 32'(busy8), 32'(0));
    end
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    chk("bad_sel_done", 32'(done_cnt), 32'(dc0));

    // A start pulse while busy must not queue a second transfer.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b1; clk_div = 8'd0; loop = 1'b1;
    sel8 = 2'd0; tx8 = 8'h69;
    @(negedge clk);
    dc0 = done_cnt;
    sb.push_back('{16'h0069, cyc + 1 + 18, 16'h0069});
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    tx8 = 8'hFF; sel8 = 2'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_sb(100, "busy_start_timeout");
    repeat (25) @(negedge clk);
    chk("busy_start_done_count", 32'(done_cnt), 32'(dc0 + 1));
    chk("busy_start_cs", 32'(cs8), 32'(3'b111));

    // Held start: three back-to-back transfers, one CS-high cycle between each.
    lsb_first = 1'b0; tx8 = 8'h5A; sel8 = 2'd1;
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    base = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back('{16'h005A, base + 18 + 19 * k, 16'h005A});
    start8 = 1'b1;
    hi = 0; d = 0; n = 0; seen = 1'b0; drop = 1'b0;
    while (d < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (drop) begin
        start8 = 1'b0;
        drop = 1'b0;
      end
      if (!seen) begin
        seen = !(&cs8);
      end else begin
        if (&cs8) hi++;
        if (done8) begin
          d++;
          if (d == 2) drop = 1'b1;
        end
      end
    end
    start8 = 1'b0;
    chk("held_done_pulses", 32'(d), 32'(3));
    chk("held_cs_high_cycles", 32'(hi), 32'(3));
    wait_sb(100, "held_timeout");
    repeat (25) @(negedge clk);
    chk("held_done_count", 32'(done_cnt), 32'(dc0 + 3));
    chk("held_idle", 32'(busy8), 32'(0));

    // Reset mid-transfer: everything returns to reset values at once, no done.
    cpol = 1'b1; cpha = 1'b1; tx8 = 8'hFF; sel8 = 2'd2;
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy8), 32'(1));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(cs8), 32'(3'b111));
    chk("mid_rst_sclk", 32'(sclk8), 32'(0));
    chk("mid_rst_mosi", 32'(mosi8), 32'(0));
    chk("mid_rst_busy", 32'(busy8), 32'(0));
    chk("mid_rst_rx", 32'(rx8), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(dc0));

    // 16-bit, 4-slave instance with the slowest divider.
    sel16 = 1'b1; cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; loop = 1'b0;
    clk_div = 8'd255; sel_16 = 2'd3; tx16 = 16'h8001; s_word = 16'h1234;
    repeat (2) @(negedge clk);
    chk("w16_idle_sclk", 32'(sclk16), 32'(0));
    cur_h = 256; toggles = 0; gap_bad = 0; cs_low_cnt = 0; last_t = -1;
    sb.push_back('{16'h1234, cyc + 1 + 256 * 34, 16'h8001});
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("w16_cs", 32'(cs16), 32'(4'b0111));
    wait_sb(9000, "w16_timeout");
    chk("w16_toggles", 32'(toggles), 32'(32));
    chk("w16_gaps", 32'(gap_bad), 32'(0));
    chk("w16_cs_low_cycles", 32'(cs_low_cnt), 32'(256 * 34));
    chk("w16_cs_release", 32'(cs16), 32'(4'b1111));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
